// File: rtl/thor2024_memsched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thor2024_memsched_pkg
// Purpose  : Shared types and constants for the Thor2024 memory-issue
//            scheduler: queue index/bitmask types, address type, access size
//            and sequencer state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package thor2024_memsched_pkg;

  localparam int QENTRIES       = 8;
  localparam int MEM_BEAT_BYTES = 16;

  typedef logic [$clog2(QENTRIES)-1:0] que_ndx_t;
  typedef logic [QENTRIES-1:0]         que_bitmask_t;
  typedef logic [31:0]                 address_t;
  typedef logic [1:0]                  mem_size_t;

  typedef enum logic [2:0] {
    MS_IDLE = 3'd0,
    MS_REQ1 = 3'd1,
    MS_RSP1 = 3'd2,
    MS_REQ2 = 3'd3,
    MS_RSP2 = 3'd4,
    MS_WB   = 3'd5
  } memsched_state_t;

endpackage
`default_nettype wire

// File: rtl/thor2024_memsched_sel.sv
`default_nettype none
// ============================================================================
// Module   : thor2024_memsched_sel
// Purpose  : Combinational oldest-first picker. Rotates the request mask so
//            head0 becomes bit 0, takes the lowest set bit and maps it back
//            to a queue index (wrapping modulo QENTRIES).
// Ports    : head0 - oldest queue index
//            req   - candidate entries
//            valid - at least one candidate present
//            idx   - chosen queue index (head0 when none)
// Revision : 1.0  initial release
// ============================================================================
module thor2024_memsched_sel
  import thor2024_memsched_pkg::*;
(
  input  que_ndx_t     head0,
  input  que_bitmask_t req,
  output logic         valid,
  output que_ndx_t     idx
);

  que_bitmask_t w_rot;

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < QENTRIES; k++) begin
      w_rot[k] = req[que_ndx_t'((int'(head0) + k) % QENTRIES)];
    end
    valid = |w_rot;
    idx   = head0;
    // Walk from the youngest down so the oldest hit wins last.
    for (int k = QENTRIES - 1; k >= 0; k--) begin
      if (w_rot[k]) idx = que_ndx_t'((int'(head0) + k) % QENTRIES);
    end
  end

endmodule
`default_nettype wire

// File: rtl/thor2024_memsched.sv
`default_nettype none
// ============================================================================
// Module   : thor2024_memsched
// Purpose  : Memory-issue scheduler/sequencer. Picks the oldest issuable
//            load/store, grants it, drives one or two 16-byte-aligned cache
//            beats, aligns load data and posts a writeback. Entries stomped
//            while in flight drain their responses but never write back.
// Ports    : clk, rst (sync, active-low)
//            head0, iqentry_memissue, iqentry_stomp, iq_adr/load/size/sdata
//            mem_grant                     - one-cycle one-hot accept pulse
//            dc_req/we/adr/sel/dat, dc_ack, dc_rvalid, dc_rdat - cache port
//            wb_valid/wb_id/wb_data        - writeback pulse
//            busy                          - sequencer not idle
// Revision : 1.0  initial release
// ============================================================================
module thor2024_memsched
  import thor2024_memsched_pkg::*;
#(
  parameter int QENTRIES = 8,   // must equal the package value
  parameter int AWID     = 32,
  parameter int LINEB    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  que_ndx_t                   head0,
  input  que_bitmask_t               iqentry_memissue,
  input  que_bitmask_t               iqentry_stomp,
  input  address_t  [QENTRIES-1:0]   iq_adr,
  input  logic      [QENTRIES-1:0]   iq_load,
  input  mem_size_t [QENTRIES-1:0]   iq_size,
  input  logic      [QENTRIES-1:0][63:0] iq_sdata,
  output que_bitmask_t               mem_grant,
  output logic                       dc_req,
  output logic                       dc_we,
  output logic [AWID-1:0]            dc_adr,
  output logic [15:0]                dc_sel,
  output logic [127:0]               dc_dat,
  input  logic                       dc_ack,
  input  logic                       dc_rvalid,
  input  logic [127:0]               dc_rdat,
  output logic                       wb_valid,
  output que_ndx_t                   wb_id,
  output logic [63:0]                wb_data,
  output logic                       busy
);

  localparam logic [2:0] C_ST_IDLE = MS_IDLE;
  localparam logic [2:0] C_ST_REQ1 = MS_REQ1;
  localparam logic [2:0] C_ST_RSP1 = MS_RSP1;
  localparam logic [2:0] C_ST_REQ2 = MS_REQ2;
  localparam logic [2:0] C_ST_RSP2 = MS_RSP2;
  localparam logic [2:0] C_ST_WB   = MS_WB;

  logic [2:0]      r_state;
  que_ndx_t        r_id;
  logic [AWID-1:0] r_adr;
  mem_size_t       r_size;
  logic            r_load;
  logic            r_kill;
  logic [63:0]     r_sdata;
  logic [63:0]     r_lo;
  logic [63:0]     r_wb_data;
  que_bitmask_t    r_grant;

  logic            w_sel_valid;
  que_ndx_t        w_sel_idx;

  thor2024_memsched_sel u_sel (
    .head0 (head0),
    .req   (iqentry_memissue & ~iqentry_stomp),
    .valid (w_sel_valid),
    .idx   (w_sel_idx)
  );

  logic [3:0]      w_off;
  logic [3:0]      w_nb;
  logic [7:0]      w_mask;
  logic            w_split;
  logic [31:0]     w_sel32;
  logic [255:0]    w_dat256;
  logic [63:0]     w_bytemask;
  logic [7:0]      w_shr;
  logic [7:0]      w_shl;
  logic [63:0]     w_lo;
  logic [63:0]     w_comb;
  logic            w_kill_now;
  logic            w_beat1_done;
  logic            w_beat2_done;
  logic [AWID-1:0] w_beat1_adr;

  always_comb begin
    w_off      = r_adr[3:0];
    w_nb       = 4'd1 << r_size;
    w_mask     = 8'((9'd1 << w_nb) - 9'd1);
    w_split    = ({1'b0, w_off} + {1'b0, w_nb}) > 5'd16;
    // Upper halves of these wide shifts are exactly the beat-2 fields.
    w_sel32    = {24'd0, w_mask} << w_off;
    w_dat256   = {192'd0, r_sdata} << {w_off, 3'b000};
    w_bytemask = '0;
    for (int b = 0; b < 8; b++) begin
      w_bytemask[8*b +: 8] = {8{w_mask[b]}};
    end
    w_shr      = {1'b0, w_off, 3'b000};
    w_shl      = 8'd128 - w_shr;
    w_lo       = 64'(dc_rdat >> w_shr);
    w_comb     = r_lo | 64'(dc_rdat << w_shl);
    // A stomp landing in the same cycle as the response still kills it.
    w_kill_now = r_kill | iqentry_stomp[r_id];
    w_beat1_adr = {r_adr[AWID-1:4], 4'h0};
    w_beat1_done = ((r_state == C_ST_REQ1) && dc_ack && dc_rvalid) ||
                   ((r_state == C_ST_RSP1) && dc_rvalid);
    w_beat2_done = ((r_state == C_ST_REQ2) && dc_ack && dc_rvalid) ||
                   ((r_state == C_ST_RSP2) && dc_rvalid);
  end

  always_comb begin
    dc_req = (r_state == C_ST_REQ1) || (r_state == C_ST_REQ2);
    dc_we  = 1'b0;
    dc_adr = '0;
    dc_sel = '0;
    dc_dat = '0;
    if (r_state == C_ST_REQ1) begin
      dc_we  = ~r_load;
      dc_adr = w_beat1_adr;
      dc_sel = w_sel32[15:0];
      dc_dat = w_dat256[127:0];
    end else if (r_state == C_ST_REQ2) begin
      dc_we  = ~r_load;
      dc_adr = w_beat1_adr + AWID'(LINEB);
      dc_sel = w_sel32[31:16];
      dc_dat = w_dat256[255:128];
    end
  end

  assign mem_grant = r_grant;
  assign busy      = (r_state != C_ST_IDLE);
  assign wb_valid  = (r_state == C_ST_WB);
  assign wb_id     = wb_valid ? r_id : '0;
  assign wb_data   = wb_valid ? r_wb_data : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= C_ST_IDLE;
      r_id      <= '0;
      r_adr     <= '0;
      r_size    <= '0;
      r_load    <= 1'b0;
      r_kill    <= 1'b0;
      r_sdata   <= '0;
      r_lo      <= '0;
      r_wb_data <= '0;
      r_grant   <= '0;
    end else begin
      r_grant <= '0;
      if (r_state == C_ST_IDLE)       r_kill <= 1'b0;
      else if (iqentry_stomp[r_id])   r_kill <= 1'b1;

      if (w_beat1_done) begin
        r_lo      <= w_lo;
        r_wb_data <= r_load ? (w_lo & w_bytemask) : '0;
        if (w_kill_now)   r_state <= C_ST_IDLE;
        else if (w_split) r_state <= C_ST_REQ2;
        else              r_state <= C_ST_WB;
      end else if (w_beat2_done) begin
        r_wb_data <= r_load ? (w_comb & w_bytemask) : '0;
        r_state   <= w_kill_now ? C_ST_IDLE : C_ST_WB;
      end else begin
        case (r_state)
          C_ST_IDLE: if (w_sel_valid) begin
            r_id    <= w_sel_idx;
            r_adr   <= AWID'(iq_adr[w_sel_idx]);
            r_size  <= iq_size[w_sel_idx];
            r_load  <= iq_load[w_sel_idx];
            r_sdata <= iq_sdata[w_sel_idx];
            r_grant <= que_bitmask_t'(1) << w_sel_idx;
            r_state <= C_ST_REQ1;
          end
          C_ST_REQ1: if (dc_ack) r_state <= C_ST_RSP1;
          C_ST_RSP1: ;
          C_ST_REQ2: if (dc_ack) r_state <= C_ST_RSP2;
          C_ST_RSP2: ;
          C_ST_WB:   r_state <= C_ST_IDLE;
          default:   r_state <= C_ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thor2024_memsched.sv
`default_nettype none
// ============================================================================
// Module   : tb_thor2024_memsched
// Purpose  : Directed self-checking bench for thor2024_memsched. Expected
//            writebacks are queued when an entry is issued and compared when
//            the DUT pulses wb_valid; cache-port fields are checked inline.
// Revision : 1.0  initial release
// ============================================================================
module tb_thor2024_memsched;
  import thor2024_memsched_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  que_ndx_t                head0 = '0;
  que_bitmask_t            iqentry_memissue = '0;
  que_bitmask_t            iqentry_stomp = '0;
  address_t  [7:0]         iq_adr = '0;
  logic      [7:0]         iq_load = '0;
  mem_size_t [7:0]         iq_size = '0;
  logic      [7:0][63:0]   iq_sdata = '0;
  que_bitmask_t            mem_grant;
  logic                    dc_req, dc_we;
  logic [31:0]             dc_adr;
  logic [15:0]             dc_sel;
  logic [127:0]            dc_dat;
  logic                    dc_ack = 1'b0;
  logic                    dc_rvalid = 1'b0;
  logic [127:0]            dc_rdat = '0;
  logic                    wb_valid;
  que_ndx_t                wb_id;
  logic [63:0]             wb_data;
  logic                    busy;

  thor2024_memsched #(.QENTRIES(8), .AWID(32), .LINEB(16)) dut (
    .clk(clk), .rst(rst), .head0(head0),
    .iqentry_memissue(iqentry_memissue), .iqentry_stomp(iqentry_stomp),
    .iq_adr(iq_adr), .iq_load(iq_load), .iq_size(iq_size), .iq_sdata(iq_sdata),
    .mem_grant(mem_grant), .dc_req(dc_req), .dc_we(dc_we), .dc_adr(dc_adr),
    .dc_sel(dc_sel), .dc_dat(dc_dat), .dc_ack(dc_ack), .dc_rvalid(dc_rvalid),
    .dc_rdat(dc_rdat), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    que_ndx_t    id;
    logic [63:0] data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int errors = 0;
  int checks = 0;

  localparam logic [127:0] RD1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] RD2 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int i, input address_t a, input logic ld,
                           input mem_size_t sz, input logic [63:0] sd);
    iq_adr[i]   = a;
    iq_load[i]  = ld;
    iq_size[i]  = sz;
    iq_sdata[i] = sd;
  endtask

  task automatic expect_wb(input que_ndx_t id, input logic [63:0] data);
    wb_exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_grant"},   mem_grant, 0);
    check({pfx, "_req"},     dc_req,    0);
    check({pfx, "_we"},      dc_we,     0);
    check({pfx, "_adr"},     dc_adr,    0);
    check({pfx, "_sel"},     dc_sel,    0);
    check({pfx, "_dat"},     dc_dat,    0);
    check({pfx, "_wbv"},     wb_valid,  0);
    check({pfx, "_wbid"},    wb_id,     0);
    check({pfx, "_wbdata"},  wb_data,   0);
    check({pfx, "_busy"},    busy,      0);
  endtask

  // Writeback scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    wb_exp_t e;
    if (rst && wb_valid) begin
      check("wb_expected_pending", 128'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wb_id", wb_id, e.id);
        check("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    // Reset
    rst = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b1;

    // Oldest-first: head0=5, entries 2 and 6 ready -> 6 first
    set_entry(6, 32'h1008, 1'b1, 2'd3, 64'h0);
    set_entry(2, 32'h100C, 1'b0, 2'd3, 64'h1122334455667788);
    head0 = 3'd5;
    iqentry_memissue = 8'b0100_0100;
    tick();
    check("ld_grant", mem_grant, 8'h40);
    check("ld_req", dc_req, 1);
    check("ld_we", dc_we, 0);
    check("ld_adr", dc_adr, 32'h1000);
    check("ld_sel", dc_sel, 16'hFF00);
    check("ld_busy", busy, 1);
    expect_wb(3'd6, 64'h0F0E0D0C0B0A0908);
    iqentry_memissue = 8'b0000_0100;
    dc_ack = 1'b1;
    tick();
    check("ld_grant_pulse", mem_grant, 0);
    check("ld_req_drop", dc_req, 0);
    dc_ack = 1'b0;
    dc_rvalid = 1'b1;
    dc_rdat = RD1;
    tick();
    check("ld_wb_valid", wb_valid, 1);
    check("no_grant_busy", mem_grant, 0);
    dc_rvalid = 1'b0;
    dc_rdat = '0;
    tick();
    check("idle_after_wb", busy, 0);
    check("wb_one_cycle", wb_valid, 0);

    // Split store (entry 2), ack withheld 5 cycles
    tick();
    check("st_grant", mem_grant, 8'h04);
    check("st_we", dc_we, 1);
    check("st_adr1", dc_adr, 32'h1000);
    check("st_sel1", dc_sel, 16'hF000);
    check("st_dat1", dc_dat, 128'h55667788 << 96);
    expect_wb(3'd2, 64'h0);
    iqentry_memissue = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_req", dc_req, 1);
      check("hold_adr", dc_adr, 32'h1000);
      check("hold_sel", dc_sel, 16'hF000);
      check("hold_dat", dc_dat, 128'h55667788 << 96);
      check("hold_grant", mem_grant, 0);
    end
    dc_ack = 1'b1;
    tick();
    check("st_req_drop", dc_req, 0);
    dc_ack = 1'b0;
    dc_rvalid = 1'b1;
    tick();
    check("st_req2", dc_req, 1);
    check("st_we2", dc_we, 1);
    check("st_adr2", dc_adr, 32'h1010);
    check("st_sel2", dc_sel, 16'h000F);
    check("st_dat2", dc_dat, 128'h11223344);
    dc_ack = 1'b1;
    dc_rvalid = 1'b1;
    tick();
    check("st_wb_valid", wb_valid, 1);
    dc_ack = 1'b0;
    dc_rvalid = 1'b0;
    tick();

    // Split load with head0 wrap (head0=6, entry 4), ack+rvalid same cycle
    set_entry(4, 32'h300D, 1'b1, 2'd2, 64'h0);
    head0 = 3'd6;
    iqentry_memissue = 8'h10;
    tick();
    check("sl_grant", mem_grant, 8'h10);
    check("sl_adr1", dc_adr, 32'h3000);
    check("sl_sel1", dc_sel, 16'hE000);
    iqentry_memissue = '0;
    expect_wb(3'd4, 64'h00000000100F0E0D);
    dc_ack = 1'b1;
    dc_rvalid = 1'b1;
    dc_rdat = RD1;
    tick();
    check("sl_req2", dc_req, 1);
    check("sl_adr2", dc_adr, 32'h3010);
    check("sl_sel2", dc_sel, 16'h0001);
    dc_rvalid = 1'b0;
    dc_rdat = '0;
    tick();
    dc_ack = 1'b0;
    dc_rvalid = 1'b1;
    dc_rdat = RD2;
    tick();
    check("sl_wb_valid", wb_valid, 1);
    dc_rvalid = 1'b0;
    dc_rdat = '0;
    tick();

    // Split load stomped in RSP1: no beat 2, no writeback
    set_entry(3, 32'h200E, 1'b1, 2'd2, 64'h0);
    head0 = 3'd0;
    iqentry_memissue = 8'h08;
    tick();
    check("sk_grant", mem_grant, 8'h08);
    check("sk_sel1", dc_sel, 16'hC000);
    iqentry_memissue = '0;
    dc_ack = 1'b1;
    tick();
    dc_ack = 1'b0;
    iqentry_stomp = 8'h08;
    tick();
    iqentry_stomp = '0;
    check("sk_busy_rsp1", busy, 1);
    dc_rvalid = 1'b1;
    dc_rdat = RD1;
    tick();
    check("sk_busy_drop", busy, 0);
    check("sk_no_req2", dc_req, 0);
    check("sk_no_wb", wb_valid, 0);
    dc_rvalid = 1'b0;
    dc_rdat = '0;
    tick();
    check("sk_still_idle", busy, 0);

    // Reset during RSP2 of a split store
    set_entry(5, 32'h400C, 1'b0, 2'd3, 64'hCAFEF00DDEADBEEF);
    iqentry_memissue = 8'h20;
    tick();
    check("rs_grant", mem_grant, 8'h20);
    iqentry_memissue = '0;
    dc_ack = 1'b1;
    tick();
    dc_ack = 1'b0;
    dc_rvalid = 1'b1;
    tick();
    dc_rvalid = 1'b0;
    dc_ack = 1'b1;
    tick();
    check("rs_in_rsp2", busy, 1);
    dc_ack = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_quiet("midreset");
    dc_rvalid = 1'b1;
    tick();
    dc_rvalid = 1'b0;
    check("stray_idle", busy, 0);
    check("stray_no_wb", wb_valid, 0);
    set_entry(1, 32'h5000, 1'b1, 2'd0, 64'h0);
    iqentry_memissue = 8'h02;
    tick();
    check("post_grant", mem_grant, 8'h02);
    check("post_adr", dc_adr, 32'h5000);
    check("post_sel", dc_sel, 16'h0001);
    iqentry_memissue = '0;
    expect_wb(3'd1, 64'hAB);
    dc_ack = 1'b1;
    dc_rvalid = 1'b1;
    dc_rdat = 128'h1234_00AB;
    tick();
    check("post_wb_valid", wb_valid, 1);
    dc_ack = 1'b0;
    dc_rvalid = 1'b0;
    dc_rdat = '0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    check("sb_drained", 128'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
